// File: rtl/glm_op_sequencer.sv
// glm_op_sequencer: program-driven scheduler for the GLM execute units.
// The host loads a small instruction memory while the block is idle. On
// start, the program runs num_iterations epochs. EXEC instructions send a
// one-cycle op_start pulse, together with operands, to the selected unit.
// Each unit's op_done pulse clears its busy bit.
module glm_op_sequencer #(
  parameter int NUM_UNITS  = 4,
  parameter int UNIT_W     = 2,
  parameter int PROG_DEPTH = 32,
  parameter int PC_W       = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 prog_we,
  input  logic [PC_W-1:0]      prog_waddr,
  input  logic [71:0]          prog_wdata,
  input  logic                 start,
  input  logic [31:0]          num_iterations,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          iteration,
  output logic [NUM_UNITS-1:0] op_start,
  output logic [31:0]          regs0,
  output logic [31:0]          regs1,
  input  logic [NUM_UNITS-1:0] op_done
);

  localparam int UNIT_SLOTS = 1 << UNIT_W;

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_DECODE    = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_DRAIN     = 3'd4;
  localparam logic [2:0] S_DONE      = 3'd5;

  localparam logic [1:0] OP_EXEC = 2'b00;
  localparam logic [1:0] OP_LOOP = 2'b01;
  localparam logic [1:0] OP_STOP = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  logic [2:0]           state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [31:0]          niter_q, niter_d;
  logic [31:0]          iter_q, iter_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_UNITS-1:0] op_start_q, op_start_d;
  logic [NUM_UNITS-1:0] unit_busy_q, unit_busy_d;
  logic [31:0]          regs0_q, regs0_d;
  logic [31:0]          regs1_q, regs1_d;
  logic [71:0]          instr_q;

  logic [71:0] mem [PROG_DEPTH];

  // Decoded fields of the instruction fetched for the current pc.
  logic [1:0]            opcode;
  logic                  wait_flag;
  logic [UNIT_W-1:0]     unit;
  logic                  unit_ok;
  logic                  unit_is_busy;
  logic [UNIT_SLOTS-1:0] busy_ext;
  logic [UNIT_SLOTS-1:0] unit_oh;
  logic                  issue;

  assign opcode    = instr_q[71:70];
  assign wait_flag = instr_q[69];
  assign unit      = instr_q[67 +: UNIT_W];
  assign unit_ok   = (32'(unit) < NUM_UNITS);
  // Pad to the full unit-field range so unused codes read as idle.
  assign busy_ext     = UNIT_SLOTS'(unit_busy_q);
  assign unit_is_busy = busy_ext[unit];
  assign unit_oh      = UNIT_SLOTS'(1) << unit;

  // Host program writes; ignored while a program is running.
  // NOTE: the instruction memory is deliberately not reset, so a loaded program survives a reset.
  always_ff @(posedge clk) begin
    if (prog_we && state_q == S_IDLE) mem[prog_waddr] <= prog_wdata;
  end

  // One-cycle synchronous instruction read, issued from FETCH.
  always_ff @(posedge clk) begin
    if (state_q == S_FETCH) instr_q <= mem[pc_q];
  end

  // Sequencer next-state logic: program flow, issue decision and epoch counting.
  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    niter_d = niter_q;
    iter_d  = iter_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    issue   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          niter_d = num_iterations;
          pc_d    = '0;
          iter_d  = '0;
          busy_d  = 1'b1;
          state_d = (num_iterations == 32'd0) ? S_DONE : S_FETCH;
        end
      end
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_EXEC: begin
            if (!unit_ok) begin
              pc_d    = pc_q + PC_W'(1);
              state_d = S_FETCH;
            end else if (!unit_is_busy) begin
              issue = 1'b1;
              if (wait_flag) begin
                state_d = S_WAIT_DONE;
              end else begin
                pc_d    = pc_q + PC_W'(1);
                state_d = S_FETCH;
              end
            end
          end
          OP_NOP: begin
            pc_d    = pc_q + PC_W'(1);
            state_d = S_FETCH;
          end
          default: state_d = S_DRAIN;
        endcase
      end
      S_WAIT_DONE: begin
        if (!unit_is_busy) begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end
      S_DRAIN: begin
        if (unit_busy_q == '0) begin
          if (opcode == OP_STOP) begin
            state_d = S_DONE;
          end else begin
            iter_d = iter_q + 32'd1;
            if (iter_d == niter_q) begin
              state_d = S_DONE;
            end else begin
              pc_d    = '0;
              state_d = S_FETCH;
            end
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Issue datapath and per-unit busy tracking. A completion pulse that
  // coincides with a fresh start for the same unit leaves it busy.
  always_comb begin
    op_start_d  = issue ? unit_oh[NUM_UNITS-1:0] : '0;
    regs0_d     = issue ? instr_q[31:0]  : regs0_q;
    regs1_d     = issue ? instr_q[63:32] : regs1_q;
    unit_busy_d = (unit_busy_q & ~(op_done & ~op_start_q)) | op_start_d;
  end

  // State registers with synchronous reset; reset aborts any running program.
  // NOTE: sequential state uses non-blocking assignments only; all decisions are made in the comb blocks above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      niter_q     <= '0;
      iter_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      op_start_q  <= '0;
      unit_busy_q <= '0;
      regs0_q     <= '0;
      regs1_q     <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      niter_q     <= niter_d;
      iter_q      <= iter_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      op_start_q  <= op_start_d;
      unit_busy_q <= unit_busy_d;
      regs0_q     <= regs0_d;
      regs1_q     <= regs1_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign iteration = iter_q;
  assign op_start  = op_start_q;
  assign regs0     = regs0_q;
  assign regs1     = regs1_q;

endmodule
